// File: rtl/pipelined_add_sub.sv
// pipelined_add_sub: WIDTH-bit adder/subtractor split into STAGES ripple-carry slices.
// Each stage adds one SW-bit slice with full-adder cells and registers the carry
// for the next stage. Operand skew and result deskew travel alongside in
// full-width registers. Only the slice owned by a stage is ever computed there.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both 1.
// The producer holds its data stable while valid is high and ready is low.
// A stage never retracts valid once it has been raised.
// The pipeline stalls globally while out_valid && !out_ready, and in_ready is
// the inverse of that stall term.
module pipelined_add_sub #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int SW = WIDTH / STAGES;

   // Pipeline state, one element per stage.
   logic             valid_q [STAGES];
   logic [WIDTH-1:0] a_q     [STAGES];
   logic [WIDTH-1:0] b_q     [STAGES];
   logic [WIDTH-1:0] sum_q   [STAGES];
   logic             carry_q [STAGES];
   logic             ovf_q;

   // Next-state values, each element driven by exactly one stage block.
   logic             valid_d [STAGES];
   logic [WIDTH-1:0] a_d     [STAGES];
   logic [WIDTH-1:0] b_d     [STAGES];
   logic [WIDTH-1:0] sum_d   [STAGES];
   logic             carry_d [STAGES];
   logic             ovf_d;

   // Inputs seen by each stage: the operands, the partial sum and the carry-in.
   logic [WIDTH-1:0] op_a    [STAGES];
   logic [WIDTH-1:0] op_b    [STAGES];
   logic [WIDTH-1:0] part_s  [STAGES];
   logic             c_in    [STAGES];

   logic             stall;
   logic [WIDTH-1:0] b_eff;
   logic             c0;

   // The last stage's skew registers have no consumer.
   logic             unused_skew;
   assign unused_skew = ^{a_q[STAGES-1], b_q[STAGES-1]};

   // Global stall: hold every register while a finished result waits downstream.
   assign stall     = out_valid & ~out_ready;
   assign in_ready  = ~stall;
   assign out_valid = valid_q[STAGES-1];
   assign sum       = sum_q[STAGES-1];
   assign cout      = carry_q[STAGES-1];
   assign ovf       = ovf_q;

   // Operand conditioning: subtraction is a + ~b + 1, so cin is ignored in sub mode.
   always_comb begin
      b_eff = sub ? ~b : b;
      c0    = sub ? 1'b1 : cin;
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [WIDTH-1:0] s_run;
      logic             c_run;

      if (k == 0) begin : g_first
         assign op_a[k]    = a;
         assign op_b[k]    = b_eff;
         assign part_s[k]  = '0;
         assign c_in[k]    = c0;
         assign valid_d[k] = in_valid;
      end else begin : g_next
         assign op_a[k]    = a_q[k-1];
         assign op_b[k]    = b_q[k-1];
         assign part_s[k]  = sum_q[k-1];
         assign c_in[k]    = carry_q[k-1];
         assign valid_d[k] = valid_q[k-1];
      end

      // Ripple-carry chain of full-adder cells over this stage's slice.
      always_comb begin
         s_run = part_s[k];
         c_run = c_in[k];
         for (int i = 0; i < SW; i++) begin
            s_run[k*SW+i] = op_a[k][k*SW+i] ^ op_b[k][k*SW+i] ^ c_run;
            c_run = (op_a[k][k*SW+i] & op_b[k][k*SW+i]) |
                    (op_a[k][k*SW+i] & c_run) |
                    (op_b[k][k*SW+i] & c_run);
         end
      end

      assign a_d[k]     = op_a[k];
      assign b_d[k]     = op_b[k];
      assign sum_d[k]   = s_run;
      assign carry_d[k] = c_run;
   end

   // Carry into the MSB is recovered from the MSB cell: cin = a ^ b ^ s.
   assign ovf_d = op_a[STAGES-1][WIDTH-1] ^ op_b[STAGES-1][WIDTH-1] ^
                  sum_d[STAGES-1][WIDTH-1] ^ carry_d[STAGES-1];

   // Pipeline registers: clear on reset, advance together when not stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++) begin
            valid_q[k] <= 1'b0;
            a_q[k]     <= '0;
            b_q[k]     <= '0;
            sum_q[k]   <= '0;
            carry_q[k] <= 1'b0;
         end
         ovf_q <= 1'b0;
      end else if (!stall) begin
         for (int k = 0; k < STAGES; k++) begin
            valid_q[k] <= valid_d[k];
            a_q[k]     <= a_d[k];
            b_q[k]     <= b_d[k];
            sum_q[k]   <= sum_d[k];
            carry_q[k] <= carry_d[k];
         end
         ovf_q <= ovf_d;
      end
   end

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Bench for pipelined_add_sub (WIDTH=16, STAGES=4): directed vectors with
// hand-computed results, checked by an in-order scoreboard.
module tb_pipelined_add_sub;
   localparam int WIDTH  = 16;
   localparam int STAGES = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic [WIDTH+1:0] exp_q [$];
   int               cyc_q [$];
   bit               chk_q [$];

   pipelined_add_sub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a        (a),
      .b        (b),
      .cin      (cin),
      .sub      (sub),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .sum      (sum),
      .cout     (cout),
      .ovf      (ovf)
   );

   // Clock and cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Driver: present one operation and hold it until it is accepted.
   task automatic send(input logic [15:0] ta, input logic [15:0] tb_, input logic tcin,
                       input logic tsub, input logic [15:0] es, input logic ec,
                       input logic eo, input bit lat);
      int waited;
      waited = 0;
      @(negedge clk);
      a = ta; b = tb_; cin = tcin; sub = tsub; in_valid = 1'b1;
      #1;
      while (!in_ready && waited < 50) begin
         @(negedge clk);
         #1;
         waited++;
      end
      if (!in_ready) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout actual=in_ready=0 required=accept within 50 cycles");
         in_valid = 1'b0;
      end else begin
         exp_q.push_back({ec, eo, es});
         cyc_q.push_back(cyc);
         chk_q.push_back(lat);
      end
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (n - 1) @(negedge clk);
   endtask

   // Monitor / scoreboard
   logic             prev_stall;
   logic [WIDTH+1:0] prev_out;
   logic [WIDTH+1:0] e_val;
   int               e_cyc;
   bit               e_chk;

   initial begin
      prev_stall = 1'b0;
      prev_out   = '0;
      forever begin
         @(negedge clk);
         #2;
         if (!rst_n) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               check("hold_valid", out_valid, 1);
               check("hold_data", {cout, ovf, sum}, prev_out);
            end
            if (out_valid && !out_ready) check("stall_in_ready", in_ready, 0);
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_output actual=0x%0h required=no output", sum);
               end else begin
                  e_val = exp_q.pop_front();
                  e_cyc = cyc_q.pop_front();
                  e_chk = chk_q.pop_front();
                  check("sum", sum, e_val[15:0]);
                  check("cout", cout, e_val[17]);
                  check("ovf", ovf, e_val[16]);
                  if (e_chk) check("latency", cyc - e_cyc, STAGES);
               end
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = {cout, ovf, sum};
         end
      end
   end

   initial begin
      int guard;
      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_sum", sum, 0);
      check("rst_cout", cout, 0);
      check("rst_ovf", ovf, 0);
      rst_n = 1'b1;
      #1;
      check("rst_in_ready", in_ready, 1);

      // Wrap-around, overflow and carry-in
      send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
      idle(8);
      send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1);
      idle(2);
      send(16'h1234, 16'h0FF0, 1'b1, 1'b0, 16'h2225, 1'b0, 1'b0, 1'b1);
      idle(6);

      // Subtraction (cin=1 must be ignored)
      send(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1);
      send(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b1);
      idle(6);

      // Eight back-to-back operations
      send(16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b1);
      send(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
      send(16'h00FF, 16'h0001, 1'b1, 1'b0, 16'h0101, 1'b0, 1'b0, 1'b1);
      send(16'h1000, 16'h0001, 1'b0, 1'b1, 16'h0FFF, 1'b1, 1'b0, 1'b1);
      send(16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
      send(16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1);
      send(16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
      send(16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b1);
      idle(8);

      // Eight operations with a three-cycle downstream stall mid-stream
      fork
         begin
            send(16'h0F0F, 16'hF0F0, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0);
            send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
            send(16'h0003, 16'h0003, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);
            send(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0);
            send(16'h0100, 16'h0200, 1'b0, 1'b1, 16'hFF00, 1'b0, 1'b0, 1'b0);
            send(16'h7000, 16'h1000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
            send(16'h9000, 16'h2000, 1'b0, 1'b1, 16'h7000, 1'b1, 1'b1, 1'b0);
            send(16'hABCD, 16'h1234, 1'b0, 1'b0, 16'hBE01, 1'b0, 1'b0, 1'b0);
            idle(1);
         end
         begin
            repeat (6) @(negedge clk);
            out_ready = 1'b0;
            repeat (3) @(negedge clk);
            out_ready = 1'b1;
         end
      join
      idle(10);

      // Reset with three operations in flight
      out_ready = 1'b0;
      send(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);
      send(16'h0002, 16'h0002, 1'b0, 1'b0, 16'h0004, 1'b0, 1'b0, 1'b0);
      send(16'h0003, 16'h0003, 1'b0, 1'b0, 16'h0006, 1'b0, 1'b0, 1'b0);
      idle(6);
      @(negedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_rst_out_valid", out_valid, 0);
      check("async_rst_sum", sum, 0);
      check("async_rst_cout", cout, 0);
      check("async_rst_ovf", ovf, 0);
      exp_q.delete();
      cyc_q.delete();
      chk_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      send(16'h00F0, 16'h000F, 1'b0, 1'b0, 16'h00FF, 1'b0, 1'b0, 1'b1);
      idle(8);

      guard = 0;
      while (exp_q.size() != 0 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain actual=%0d pending required=0 pending", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
